spi_ram_ctrl: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 14 +
 rtl/spi_ram_mem.sv | 23 ++
 rtl/spi_ram_ctrl.sv | 86 ++++++++
 tb/tb_spi_ram_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-fed RAM command stage.
package spi_ram_pkg;
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {IDLE, TX_HOLD} state_e;

  localparam int CMD_MSB = 9;
  localparam int CMD_LSB = 8;
endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte RAM: synchronous write, registered read; only the read register resets.
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // rdata only moves on a read, so later writes never disturb a word being shifted out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI slave command words into RAM address/data writes and reads.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH     = 256,
  parameter int ADDR_SIZE     = 8,
  parameter bit ADDR_AUTO_INC = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       seq_err
);
  logic                 rx_valid_q, rx_armed, accept, rd_addr_vld;
  logic                 mem_we, mem_re;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, mem_addr;
  cmd_e                 cmd;
  state_e               state, state_nxt;

  assign cmd = cmd_e'(din[CMD_MSB:CMD_LSB]);
  // rx_armed blocks a level that was already high when reset released
  assign accept   = rx_valid & ~rx_valid_q & rx_armed;
  assign tx_valid = (state == TX_HOLD);

  always_comb begin
    mem_we    = accept && (cmd == WR_DATA);
    mem_re    = accept && (cmd == RD_DATA);
    mem_addr  = (cmd == RD_DATA) ? rd_addr : wr_addr;
    state_nxt = state;
    if (accept) state_nxt = (cmd == RD_DATA) ? TX_HOLD : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q  <= 1'b0;
      rx_armed    <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      rx_armed   <= rx_armed | ~rx_valid;
      if (accept) begin
        unique case (cmd)
          WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
          WR_DATA: if (ADDR_AUTO_INC) wr_addr <= wr_addr + 1'b1;
          RD_ADDR: begin
            rd_addr     <= din[ADDR_SIZE-1:0];
            rd_addr_vld <= 1'b1;
          end
          RD_DATA: begin
            // stale-address reads still execute; the flag just records it
            if (!rd_addr_vld) seq_err <= 1'b1;
            rd_addr_vld <= 1'b0;
            if (ADDR_AUTO_INC) rd_addr <= rd_addr + 1'b1;
          end
        endcase
      end
    end
  end

  spi_ram_mem #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (din[7:0]),
    .rdata (dout)
  );

  a_cmd_known: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> !$isunknown(din[CMD_MSB:CMD_LSB]));
  a_tx_rise: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(tx_valid) |-> $past(mem_re));
  a_dout_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (tx_valid && $past(tx_valid) && !$past(mem_re)) |-> $stable(dout));
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Drives two controllers (auto-increment off/on) with the same command stream against a command-level model.
module tb_spi_ram_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout [2];
  logic       tx_valid [2];
  logic       seq_err [2];

  int checks = 0;
  int errors = 0;

  // model state, index 0 = no auto-increment, 1 = auto-increment
  int m_mem [2][256];
  bit m_kn  [2][256];
  int m_wa [2], m_ra [2], m_dout [2];
  bit m_rv [2], m_dk [2], m_tx [2], m_se [2];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .ADDR_AUTO_INC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout[0]), .tx_valid(tx_valid[0]), .seq_err(seq_err[0]));

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .ADDR_AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout[1]), .tx_valid(tx_valid[1]), .seq_err(seq_err[1]));

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_rv[i] = 0;
      m_dout[i] = 0; m_dk[i] = 1; m_tx[i] = 0; m_se[i] = 0;
    end
  endtask

  task automatic model_cmd(logic [9:0] w);
    int c = int'(w[9:8]);
    int p = int'(w[7:0]);
    for (int i = 0; i < 2; i++) begin
      case (c)
        0: m_wa[i] = p;
        1: begin
          m_mem[i][m_wa[i]] = p;
          m_kn[i][m_wa[i]]  = 1;
          if (i == 1) m_wa[i] = (m_wa[i] + 1) % 256;
        end
        2: begin m_ra[i] = p; m_rv[i] = 1; end
        default: begin
          if (!m_rv[i]) m_se[i] = 1;
          m_dout[i] = m_mem[i][m_ra[i]];
          m_dk[i]   = m_kn[i][m_ra[i]];
          m_rv[i]   = 0;
          if (i == 1) m_ra[i] = (m_ra[i] + 1) % 256;
        end
      endcase
      m_tx[i] = (c == 3);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), {7'b0, tx_valid[i]}, {7'b0, m_tx[i]});
      chk($sformatf("%s_se%0d", tag, i), {7'b0, seq_err[i]}, {7'b0, m_se[i]});
      if (m_dk[i]) chk($sformatf("%s_dout%0d", tag, i), dout[i], 8'(m_dout[i]));
    end
  endtask

  // one command word, rx_valid held for 'hold' cycles, then one low cycle
  task automatic send(logic [9:0] w, int hold = 1);
    din = w; rx_valid = 1'b1;
    @(negedge clk);
    model_cmd(w);
    check_all($sformatf("acc_%h", w));
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      check_all($sformatf("hold_%h", w));
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check_all($sformatf("gap_%h", w));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    din = '0; rx_valid = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // write then read
    send(10'h0A5); send(10'h13C); send(10'h2A5);
    din = 10'h300; rx_valid = 1'b1;
    @(negedge clk);
    model_cmd(10'h300);
    check_all("wr_rd");
    chk("wr_rd_dout0", dout[0], 8'h3C);
    chk("wr_rd_dout1", dout[1], 8'h3C);
    chk("wr_rd_tx0", {7'b0, tx_valid[0]}, 8'h01);
    rx_valid = 1'b0;
    @(negedge clk);
    check_all("wr_rd_gap");

    // leaving TX_HOLD on a non-read command
    send(10'h010);
    chk("term_tx0", {7'b0, tx_valid[0]}, 8'h00);
    chk("term_dout0", dout[0], 8'h3C);

    // held rx_valid writes once; 0x11 pre-cleared so a second write would show
    send(10'h011); send(10'h100);
    send(10'h010); send(10'h155, 12);
    send(10'h210); send(10'h300);
    chk("held_mem10", dout[0], 8'h55);
    send(10'h211); send(10'h300);
    chk("held_mem11_0", dout[0], 8'h00);
    chk("held_mem11_1", dout[1], 8'h00);

    // sequence error after reset, using a known mem[0]
    send(10'h000); send(10'h1C3);
    do_reset();
    send(10'h300);
    chk("seq_se0", {7'b0, seq_err[0]}, 8'h01);
    chk("seq_dout0", dout[0], 8'hC3);
    send(10'h2FF); send(10'h300);
    chk("seq_sticky1", {7'b0, seq_err[1]}, 8'h01);

    // auto-increment wrap
    send(10'h0FF); send(10'h111); send(10'h122); send(10'h2FF);
    send(10'h300);
    chk("wrap_first1", dout[1], 8'h11);
    din = 10'h300; rx_valid = 1'b1;
    @(negedge clk);
    model_cmd(10'h300);
    check_all("wrap2");
    chk("wrap_second1", dout[1], 8'h22);
    chk("wrap_tx1", {7'b0, tx_valid[1]}, 8'h01);

    // async reset mid-hold, released with rx_valid already high
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_dout1", dout[1], 8'h00);
    din = 10'h300; rx_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all("no_acc");
    end
    rx_valid = 1'b0;
    @(negedge clk);
    send(10'h300);
    chk("rearm_tx0", {7'b0, tx_valid[0]}, 8'h01);

    // random command stream
    for (int n = 0; n < 200; n++) begin
      logic [1:0] c;
      logic [7:0] p;
      c = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      send({c, p}, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
